multicycle_controller: RTL and testbench

Main control FSM for the multicycle RV32I core. Decodes the 7-bit opcode, sequences each instruction through fetch, decode, execute, memory and writeback, and drives the datapath enables and mux selects. It is the producer of the 2-bit ALUOp field consumed by the ALU operation decoder, together with instruction bits Funct3 and Funct7. Memory accesses use a ready handshake, so the number of cycles per instruction depends on memory latency.

---
 rtl/controller_pkg.sv | 84 ++++++++
 rtl/ctrl_out_decode.sv | 92 +++++++++
 rtl/multicycle_controller.sv | 112 +++++++++++
 tb/tb_multicycle_controller.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/controller_pkg.sv
// Shared encodings for the multicycle RV32I main controller: FSM states,
// opcodes, ALUOp and datapath mux selects, and the control word bundle.
// Optional feature macro: CTRL_HALT_EN (adds the HALT state for SYSTEM opcodes).
package controller_pkg;

   // RV32I major opcodes (instruction bits [6:0])
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_ITYPE  = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_SYSTEM = 7'b1110011;

   // ALUOp field handed to the ALU operation decoder
   localparam logic [1:0] ALUOP_ADD    = 2'b00;
   localparam logic [1:0] ALUOP_BRANCH = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT  = 2'b10;

   // ALU operand A select
   localparam logic [1:0] SRCA_PC    = 2'b00;
   localparam logic [1:0] SRCA_OLDPC = 2'b01;
   localparam logic [1:0] SRCA_REGA  = 2'b10;
   localparam logic [1:0] SRCA_ZERO  = 2'b11;

   // ALU operand B select
   localparam logic [1:0] SRCB_REGB = 2'b00;
   localparam logic [1:0] SRCB_IMM  = 2'b01;
   localparam logic [1:0] SRCB_FOUR = 2'b10;

   // Result bus select
   localparam logic [1:0] RES_ALUOUT    = 2'b00;
   localparam logic [1:0] RES_DATA      = 2'b01;
   localparam logic [1:0] RES_ALURESULT = 2'b10;

   typedef enum logic [3:0] {
      S_FETCH,
      S_DECODE,
      S_MEMADR,
      S_MEMREAD,
      S_MEMWB,
      S_MEMWRITE,
      S_EXEC_R,
      S_EXEC_I,
      S_ALUWB,
      S_BRANCH,
      S_JAL,
      S_LUI,
      S_AUIPC
`ifdef CTRL_HALT_EN
      , S_HALT
`endif
   } ctrl_state_t;

   // Datapath control word produced by the output decoder
   typedef struct packed {
      logic [1:0] alu_op;
      logic [1:0] alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] result_src;
      logic       adr_src;
      logic       mem_read;
      logic       mem_write;
      logic       ir_write;
      logic       pc_write;
      logic       branch;
      logic       reg_write;
   } ctrl_word_t;

   // True when DECODE has somewhere legal to send this opcode
   function automatic logic opcode_supported(input logic [6:0] op);
      case (op)
         OP_LOAD, OP_STORE, OP_RTYPE, OP_ITYPE,
         OP_BRANCH, OP_JAL, OP_LUI, OP_AUIPC: return 1'b1;
`ifdef CTRL_HALT_EN
         OP_SYSTEM:                           return 1'b1;
`endif
         default:                             return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/ctrl_out_decode.sv
// Combinational map from controller state (plus MemReady in FETCH) to the
// datapath control word. Everything not named for a state stays 0.
module ctrl_out_decode
   import controller_pkg::*;
(
   input  ctrl_state_t state,
   input  logic        mem_ready,
   output ctrl_word_t  ctrl
);

   // Per-state control word; IRWrite/PCWrite in FETCH follow MemReady
   always_comb begin
      // NOTE: default every field first so no path through the case infers a latch.
      ctrl = '0;
      case (state)
         S_FETCH: begin
            ctrl.adr_src    = 1'b0;
            ctrl.mem_read   = 1'b1;
            ctrl.alu_src_a  = SRCA_PC;
            ctrl.alu_src_b  = SRCB_FOUR;
            ctrl.alu_op     = ALUOP_ADD;
            ctrl.result_src = RES_ALURESULT;
            ctrl.ir_write   = mem_ready;
            ctrl.pc_write   = mem_ready;
         end
         S_DECODE: begin
            ctrl.alu_src_a = SRCA_OLDPC;
            ctrl.alu_src_b = SRCB_IMM;
            ctrl.alu_op    = ALUOP_ADD;
         end
         S_MEMADR: begin
            ctrl.alu_src_a = SRCA_REGA;
            ctrl.alu_src_b = SRCB_IMM;
            ctrl.alu_op    = ALUOP_ADD;
         end
         S_MEMREAD: begin
            ctrl.adr_src    = 1'b1;
            ctrl.result_src = RES_ALUOUT;
            ctrl.mem_read   = 1'b1;
         end
         S_MEMWB: begin
            ctrl.result_src = RES_DATA;
            ctrl.reg_write  = 1'b1;
         end
         S_MEMWRITE: begin
            ctrl.adr_src    = 1'b1;
            ctrl.result_src = RES_ALUOUT;
            ctrl.mem_write  = 1'b1;
         end
         S_EXEC_R: begin
            ctrl.alu_src_a = SRCA_REGA;
            ctrl.alu_src_b = SRCB_REGB;
            ctrl.alu_op    = ALUOP_FUNCT;
         end
         S_EXEC_I: begin
            ctrl.alu_src_a = SRCA_REGA;
            ctrl.alu_src_b = SRCB_IMM;
            ctrl.alu_op    = ALUOP_FUNCT;
         end
         S_ALUWB: begin
            ctrl.result_src = RES_ALUOUT;
            ctrl.reg_write  = 1'b1;
         end
         S_BRANCH: begin
            ctrl.alu_src_a  = SRCA_REGA;
            ctrl.alu_src_b  = SRCB_REGB;
            ctrl.alu_op     = ALUOP_BRANCH;
            ctrl.result_src = RES_ALUOUT;
            ctrl.branch     = 1'b1;
         end
         S_JAL: begin
            ctrl.alu_src_a  = SRCA_OLDPC;
            ctrl.alu_src_b  = SRCB_FOUR;
            ctrl.alu_op     = ALUOP_ADD;
            ctrl.result_src = RES_ALUOUT;
            ctrl.pc_write   = 1'b1;
         end
         S_LUI: begin
            ctrl.alu_src_a = SRCA_ZERO;
            ctrl.alu_src_b = SRCB_IMM;
            ctrl.alu_op    = ALUOP_ADD;
         end
         S_AUIPC: begin
            ctrl.alu_src_a = SRCA_OLDPC;
            ctrl.alu_src_b = SRCB_IMM;
            ctrl.alu_op    = ALUOP_ADD;
         end
         default: ctrl = '0;
      endcase
   end

endmodule

// File: rtl/multicycle_controller.sv
// Main control FSM of the multicycle RV32I core: state register, next-state
// logic, and output stage (control word from ctrl_out_decode, gated by reset).
// Optional feature macro: CTRL_HALT_EN (SYSTEM opcode parks the core in HALT).
module multicycle_controller
   import controller_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [6:0] Opcode,
   input  logic       MemReady,
   output logic [1:0] ALUOp,
   output logic [1:0] ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [1:0] ResultSrc,
   output logic       AdrSrc,
   output logic       MemRead,
   output logic       MemWrite,
   output logic       IRWrite,
   output logic       PCWrite,
   output logic       Branch,
   output logic       RegWrite,
   output logic       IllegalInstr,
   output logic       Halted
);

   ctrl_state_t state_q;
   ctrl_state_t state_d;
   ctrl_word_t  ctrl;
   ctrl_word_t  ctrl_out;
   logic        illegal;
   logic        halted;

   // State register with synchronous reset to FETCH
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
      if (reset) begin
         state_q <= S_FETCH;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state: Opcode matters only in DECODE and MEMADR, MemReady only in memory waits
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_FETCH:    if (MemReady) state_d = S_DECODE;
         S_DECODE: begin
            case (Opcode)
               OP_LOAD, OP_STORE: state_d = S_MEMADR;
               OP_RTYPE:          state_d = S_EXEC_R;
               OP_ITYPE:          state_d = S_EXEC_I;
               OP_BRANCH:         state_d = S_BRANCH;
               OP_JAL:            state_d = S_JAL;
               OP_LUI:            state_d = S_LUI;
               OP_AUIPC:          state_d = S_AUIPC;
`ifdef CTRL_HALT_EN
               OP_SYSTEM:         state_d = S_HALT;
`endif
               default:           state_d = S_FETCH;
            endcase
         end
         S_MEMADR:   state_d = Opcode[5] ? S_MEMWRITE : S_MEMREAD;
         S_MEMREAD:  if (MemReady) state_d = S_MEMWB;
         S_MEMWB:    state_d = S_FETCH;
         S_MEMWRITE: if (MemReady) state_d = S_FETCH;
         S_EXEC_R, S_EXEC_I, S_JAL, S_LUI, S_AUIPC: state_d = S_ALUWB;
         S_ALUWB, S_BRANCH: state_d = S_FETCH;
`ifdef CTRL_HALT_EN
         S_HALT:     state_d = S_HALT;
`endif
         default:    state_d = S_FETCH;
      endcase
   end

   ctrl_out_decode u_out_decode (
      .state     (state_q),
      .mem_ready (MemReady),
      .ctrl      (ctrl)
   );

   // Output stage: reset forces every output low, abandoning any in-flight access
   always_comb begin
      ctrl_out = ctrl;
      illegal  = (state_q == S_DECODE) && !opcode_supported(Opcode);
`ifdef CTRL_HALT_EN
      halted   = (state_q == S_HALT);
`else
      halted   = 1'b0;
`endif
      if (reset) begin
         ctrl_out = '0;
         illegal  = 1'b0;
         halted   = 1'b0;
      end
   end

   assign ALUOp        = ctrl_out.alu_op;
   assign ALUSrcA      = ctrl_out.alu_src_a;
   assign ALUSrcB      = ctrl_out.alu_src_b;
   assign ResultSrc    = ctrl_out.result_src;
   assign AdrSrc       = ctrl_out.adr_src;
   assign MemRead      = ctrl_out.mem_read;
   assign MemWrite     = ctrl_out.mem_write;
   assign IRWrite      = ctrl_out.ir_write;
   assign PCWrite      = ctrl_out.pc_write;
   assign Branch       = ctrl_out.branch;
   assign RegWrite     = ctrl_out.reg_write;
   assign IllegalInstr = illegal;
   assign Halted       = halted;

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller. For each instruction a
// reference model expands the opcode and memory wait counts into the expected
// per-cycle control words, which are then compared cycle by cycle.
module tb_multicycle_controller;

   logic       clk = 1'b0;
   logic       reset;
   logic [6:0] Opcode;
   logic       MemReady;
   logic [1:0] ALUOp, ALUSrcA, ALUSrcB, ResultSrc;
   logic       AdrSrc, MemRead, MemWrite, IRWrite, PCWrite, Branch, RegWrite;
   logic       IllegalInstr, Halted;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic [1:0] alu_op;
      logic [1:0] src_a;
      logic [1:0] src_b;
      logic [1:0] res_src;
      logic       adr_src;
      logic       mem_read;
      logic       mem_write;
      logic       ir_write;
      logic       pc_write;
      logic       branch;
      logic       reg_write;
      logic       illegal;
      logic       halted;
   } word_t;

   typedef struct {
      word_t exp;
      logic  rst;
      logic  mr;
      logic  drive_op;
   } beat_t;

   beat_t q[$];
   word_t obs;

   assign obs = {ALUOp, ALUSrcA, ALUSrcB, ResultSrc, AdrSrc, MemRead, MemWrite,
                 IRWrite, PCWrite, Branch, RegWrite, IllegalInstr, Halted};

   multicycle_controller dut (
      .clk          (clk),
      .reset        (reset),
      .Opcode       (Opcode),
      .MemReady     (MemReady),
      .ALUOp        (ALUOp),
      .ALUSrcA      (ALUSrcA),
      .ALUSrcB      (ALUSrcB),
      .ResultSrc    (ResultSrc),
      .AdrSrc       (AdrSrc),
      .MemRead      (MemRead),
      .MemWrite     (MemWrite),
      .IRWrite      (IRWrite),
      .PCWrite      (PCWrite),
      .Branch       (Branch),
      .RegWrite     (RegWrite),
      .IllegalInstr (IllegalInstr),
      .Halted       (Halted)
   );

   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   function automatic logic legal_op(input logic [6:0] op);
      logic [6:0] ok [8] = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
                            7'b1100011, 7'b1101111, 7'b0110111, 7'b0010111};
      foreach (ok[i]) if (op == ok[i]) return 1'b1;
      return 1'b0;
   endfunction

   // Expected control word for one phase of an instruction, taken from the
   // controller's phase table; flag is MemReady in fetch, "illegal" in decode.
   function automatic word_t phase(input string name, input logic flag);
      word_t e = '0;
      case (name)
         "fetch":   begin e.mem_read = 1; e.src_b = 2'b10; e.res_src = 2'b10;
                          e.ir_write = flag; e.pc_write = flag; end
         "decode":  begin e.src_a = 2'b01; e.src_b = 2'b01; e.illegal = flag; end
         "memadr":  begin e.src_a = 2'b10; e.src_b = 2'b01; end
         "memread": begin e.adr_src = 1; e.mem_read = 1; end
         "memwb":   begin e.res_src = 2'b01; e.reg_write = 1; end
         "memwr":   begin e.adr_src = 1; e.mem_write = 1; end
         "exec_r":  begin e.src_a = 2'b10; e.alu_op = 2'b10; end
         "exec_i":  begin e.src_a = 2'b10; e.src_b = 2'b01; e.alu_op = 2'b10; end
         "aluwb":   begin e.reg_write = 1; end
         "branch":  begin e.src_a = 2'b10; e.alu_op = 2'b01; e.branch = 1; end
         "jal":     begin e.src_a = 2'b01; e.src_b = 2'b10; e.pc_write = 1; end
         "lui":     begin e.src_a = 2'b11; e.src_b = 2'b01; end
         "auipc":   begin e.src_a = 2'b01; e.src_b = 2'b01; end
         "halt":    begin e.halted = 1; end
         default:   e = '0;
      endcase
      return e;
   endfunction

   function automatic void push(input word_t e, input logic rst, input logic mr, input logic dop);
      beat_t b;
      b.exp = e; b.rst = rst; b.mr = mr; b.drive_op = dop;
      q.push_back(b);
   endfunction

   // Memory-handshake phase: `waits` cycles with MemReady low, then one with it high
   function automatic void push_waited(input string name, input int waits);
      for (int i = 0; i < waits; i++) push(phase(name, 1'b0), 1'b0, 1'b0, 1'b0);
      push(phase(name, 1'b1), 1'b0, 1'b1, 1'b0);
   endfunction

   // Expand one instruction into its expected cycle trace (appended to q).
   // When stop_in_memwrite is set, a store stops after one MemReady=0 cycle.
   function automatic void model_instr(input logic [6:0] op, input int fw, input int mw,
                                       input logic stop_in_memwrite);
      push_waited("fetch", fw);
      push(phase("decode", !legal_op(op)), 1'b0, $urandom_range(0, 1), 1'b1);
      if (op == 7'b0000011 || op == 7'b0100011) begin
         push(phase("memadr", 1'b0), 1'b0, $urandom_range(0, 1), 1'b1);
         if (op == 7'b0000011) begin
            push_waited("memread", mw);
            push(phase("memwb", 1'b0), 1'b0, $urandom_range(0, 1), 1'b0);
         end else if (stop_in_memwrite) begin
            push(phase("memwr", 1'b0), 1'b0, 1'b0, 1'b0);
         end else begin
            push_waited("memwr", mw);
         end
      end else begin
         case (op)
            7'b0110011: push(phase("exec_r", 1'b0), 1'b0, $urandom_range(0, 1), 1'b0);
            7'b0010011: push(phase("exec_i", 1'b0), 1'b0, $urandom_range(0, 1), 1'b0);
            7'b1100011: push(phase("branch", 1'b0), 1'b0, $urandom_range(0, 1), 1'b0);
            7'b1101111: push(phase("jal",    1'b0), 1'b0, $urandom_range(0, 1), 1'b0);
            7'b0110111: push(phase("lui",    1'b0), 1'b0, $urandom_range(0, 1), 1'b0);
            7'b0010111: push(phase("auipc",  1'b0), 1'b0, $urandom_range(0, 1), 1'b0);
            default: ;
         endcase
         if (op inside {7'b0110011, 7'b0010011, 7'b1101111, 7'b0110111, 7'b0010111})
            push(phase("aluwb", 1'b0), 1'b0, $urandom_range(0, 1), 1'b0);
      end
   endfunction

   // ---------------- stimulus ----------------
   task automatic step(input logic rst, input logic [6:0] op, input logic mr, output word_t got);
      reset    = rst;
      Opcode   = op;
      MemReady = mr;
      @(negedge clk);
      got = obs;
      @(posedge clk);
      #1;
   endtask

   // Play q against the DUT; Opcode is the instruction's only where it is sampled
   task automatic play(input logic [6:0] op, input string tag);
      word_t got;
      int    n = 0;
      while (q.size() > 0) begin
         beat_t b = q.pop_front();
         step(b.rst, b.drive_op ? op : 7'($urandom), b.mr, got);
         checks++;
         if (got !== b.exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %05h expected %05h", tag, n, got, b.exp);
         end
         checks++;
         if ((got.mem_read && got.mem_write) || (got.pc_write && got.branch)) begin
            errors++;
            $display("FAIL %s cycle %0d exclusive enables: got %05h", tag, n, got);
         end
         n++;
      end
   endtask

   task automatic run_instr(input logic [6:0] op, input int fw, input int mw, input string tag);
      model_instr(op, fw, mw, 1'b0);
      play(op, tag);
   endtask

   task automatic test_reset();
      for (int i = 0; i < 3; i++) push('0, 1'b1, $urandom_range(0, 1), 1'b0);
      play(7'b0110011, "reset");
   endtask

   task automatic test_rtype();
      run_instr(7'b0110011, 0, 0, "rtype");
   endtask

   task automatic test_lw_waits();
      run_instr(7'b0000011, 0, 2, "lw_waits");
   endtask

   task automatic test_beq();
      run_instr(7'b1100011, 0, 0, "beq");
   endtask

   task automatic test_illegal();
      run_instr(7'b1111111, 0, 0, "illegal");
`ifndef CTRL_HALT_EN
      run_instr(7'b1110011, 1, 0, "system_illegal");
`endif
   endtask

   task automatic test_reset_in_memwrite();
      model_instr(7'b0100011, 0, 0, 1'b1);
      push('0, 1'b1, 1'b0, 1'b0);
      play(7'b0100011, "reset_memwrite");
      run_instr(7'b0010011, 0, 0, "after_reset");
   endtask

   task automatic test_halt();
`ifdef CTRL_HALT_EN
      push_waited("fetch", 0);
      push(phase("decode", 1'b0), 1'b0, 1'b1, 1'b1);
      for (int i = 0; i < 20; i++) push(phase("halt", 1'b0), 1'b0, $urandom_range(0, 1), 1'b0);
      push('0, 1'b1, 1'b1, 1'b0);
      play(7'b1110011, "halt");
      run_instr(7'b0110111, 0, 0, "after_halt");
`endif
   endtask

   task automatic test_random();
      logic [6:0] ops [8] = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
                             7'b1100011, 7'b1101111, 7'b0110111, 7'b0010111};
      for (int i = 0; i < 60; i++) begin
         logic [6:0] op;
         if ($urandom_range(0, 7) == 0) begin
            do op = 7'($urandom); while (legal_op(op) || op == 7'b1110011);
         end else begin
            op = ops[$urandom_range(0, 7)];
         end
         run_instr(op, $urandom_range(0, 3), $urandom_range(0, 3), "random");
      end
   endtask

   task automatic test_back_to_back();
      run_instr(7'b0100011, 0, 0, "b2b_sw");
      run_instr(7'b0000011, 0, 0, "b2b_lw");
      run_instr(7'b1101111, 2, 0, "b2b_jal");
      run_instr(7'b0010111, 0, 0, "b2b_auipc");
   endtask

   initial begin
      reset    = 1'b1;
      Opcode   = '0;
      MemReady = 1'b0;
      test_reset();
      test_rtype();
      test_lw_waits();
      test_beq();
      test_illegal();
      test_reset_in_memwrite();
      test_back_to_back();
      test_random();
      test_halt();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
